mybldc_axil_selftest: RTL
=========================

MYBLDC_AXIL_SELFTEST -- requirements
Module: mybldc_axil_selftest

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the AXI4-Lite data width (32 or 64).
REQ-002 Parameter NUM_REGS, default 4, sets the registers exercised per pass (1..256).
REQ-003 Parameter BASE_ADDR, default 32'h0, sets the address of register 0.
REQ-004 Parameter START_VALUE, default 1, sets the data written to register 0 on the first pass.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024, sets the maximum wait for any single handshake.
REQ-006 ACLK  in  1  sole clock; all logic rising-edge.
REQ-007 ARESET  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to begin a test; sampled only in IDLE.
REQ-009 loop_mode  in  1  repeat passes until cleared.
REQ-010 busy, done, pass, timeout  out  1 each  status; done is a 1-cycle pulse per completed pass.
REQ-011 err_count  out  16  saturating mismatch/response-error count.
REQ-012 M_AXI_AWADDR/ARADDR  out  32;  AWPROT/ARPROT  out  3 (tied 0);  AWVALID/ARVALID  out  1;  AWREADY/ARREADY  in  1.
REQ-013 M_AXI_WDATA  out  DATA_WIDTH;  WSTRB  out  DATA_WIDTH/8 (all ones);  WVALID  out  1;  WREADY  in  1.
REQ-014 M_AXI_BRESP  in  2;  BVALID  in  1;  BREADY  out  1.
REQ-015 M_AXI_RDATA  in  DATA_WIDTH;  RRESP  in  2;  RVALID  in  1;  RREADY  out  1.

Function
REQ-016 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-017 IDLE: start=1 -> WR_REQ next cycle; index i=0, seed=START_VALUE, err_count=0, timeout=0, pass=0; busy=1 from that cycle.
REQ-018 WR_REQ: AWVALID and WVALID assert together; each drops independently on its own handshake; both handshaked -> WR_RESP. Handshakes in either order or in the same cycle are accepted.
REQ-019 Write address = BASE_ADDR + 4*i (DATA_WIDTH 32) or + 8*i (64); write data = seed + i, truncated modulo 2^DATA_WIDTH.
REQ-020 WR_RESP: BREADY=1; on BVALID, BRESP!=OKAY increments err_count; then i+1, or i=0 and -> RD_REQ after the last register.
REQ-021 RD_REQ: ARVALID=1 with the same address formula; ARREADY -> RD_RESP.
REQ-022 RD_RESP: RREADY=1; on RVALID, RDATA!=seed+i or RRESP!=OKAY increments err_count by 1 (never by 2); after the last register -> DONE.
REQ-023 VALID outputs, once asserted, hold with stable address and data until handshake, except on timeout or reset.
REQ-024 err_count saturates at 16'hFFFF.
REQ-025 A per-handshake wait counter resets on each state entry; reaching TIMEOUT_CYCLES sets timeout=1, increments err_count, drops all VALID/READY, and -> DONE.
REQ-026 DONE (one cycle): done=1, pass=(err_count==0 and timeout==0). If loop_mode=1 and timeout=0: seed+=NUM_REGS, i=0, -> WR_REQ; otherwise -> IDLE with busy=0.
REQ-027 pass, err_count and timeout hold until the next accepted start; start while busy is ignored.
REQ-028 At most one outstanding transaction per channel; no read is issued until all writes of the pass complete.

Reset
REQ-029 ARESET=1 immediately forces state IDLE and all outputs 0 (including every VALID/READY, err_count, and address/data buses), independent of ACLK; an in-flight transaction is abandoned.

Verification
REQ-030 Defaults, memory-model slave with zero-wait READY, start pulse -> writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then reads; done pulse, pass=1, err_count=0.
REQ-031 Slave corrupts the read of 0x8 (returns 0) -> err_count=1, pass=0; other three compare OK.
REQ-032 AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID holds for 4 cycles, exactly one write per register.
REQ-033 Slave never asserts BVALID, TIMEOUT_CYCLES=16 -> timeout=1 after 16 waiting cycles, err_count=1, done pulses, busy=0.
REQ-034 loop_mode=1 for two passes, NUM_REGS=4 -> the second pass writes 5..8; clearing loop_mode ends the run after the current pass; done pulses twice.
REQ-035 ARESET asserted during RD_RESP -> same-cycle RREADY=0, busy=0, state IDLE; a subsequent start runs a clean pass with err_count=0.

Source files
------------

// File: rtl/mybldc_axil_selftest_if.sv
// AXI4-Lite bus bundle for the self-test master. The master modport drives the
// request side of each channel; the slave modport is its mirror.
interface mybldc_axil_selftest_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [31:0]             AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [31:0]             ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/mybldc_axil_selftest.sv
// AXI4-Lite write-then-readback self-test master: writes seed+i to NUM_REGS
// registers, reads them back, counts mismatches, optionally loops with a new seed.
module mybldc_axil_selftest #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           NUM_REGS       = 4,
  parameter logic [31:0]           BASE_ADDR      = 32'h0,
  parameter logic [DATA_WIDTH-1:0] START_VALUE    = DATA_WIDTH'(1),
  parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  input  logic        loop_mode,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  mybldc_axil_selftest_if.master m_axi
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_e;

  localparam int unsigned           IDX_W      = 9;
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_REGS - 1);
  localparam int unsigned           ADDR_SHIFT = (DATA_WIDTH == 64) ? 3 : 2;
  localparam logic [31:0]           WAIT_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] SEED_STEP  = DATA_WIDTH'(NUM_REGS);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d, wdata_q, wdata_d;
  logic [31:0]           addr_q, addr_d, wait_q, wait_d;
  logic [15:0]           err_q, err_d;
  logic                  timeout_q, timeout_d, pass_q, pass_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                  is_last, pass_now, rd_bad;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] reg_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + (32'(i) << ADDR_SHIFT);
  endfunction

  assign is_last  = (idx_q == LAST_IDX);
  assign pass_now = (err_q == 16'd0) && !timeout_q;
  // A bad response and a data mismatch on the same beat count as one error.
  assign rd_bad   = (m_axi.RDATA != (seed_q + DATA_WIDTH'(idx_q))) || (m_axi.RRESP != 2'b00);

  always_comb begin
    // NOTE: every variable written here is defaulted first, so no path can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    seed_d    = seed_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    wait_d    = wait_q + 32'd1;
    err_d     = err_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;

    case (state_q)
      IDLE: if (start) begin
        state_d   = WR_REQ;
        idx_d     = '0;
        seed_d    = START_VALUE;
        err_d     = '0;
        timeout_d = 1'b0;
        pass_d    = 1'b0;
      end
      WR_REQ: begin
        if (m_axi.AWREADY) awvalid_d = 1'b0;
        if (m_axi.WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: if (m_axi.BVALID) begin
        if (m_axi.BRESP != 2'b00) err_d = sat_inc(err_q);
        idx_d   = is_last ? '0 : idx_q + 1'b1;
        state_d = is_last ? RD_REQ : WR_REQ;
      end
      RD_REQ: if (m_axi.ARREADY) begin
        arvalid_d = 1'b0;
        state_d   = RD_RESP;
      end
      RD_RESP: if (m_axi.RVALID) begin
        if (rd_bad) err_d = sat_inc(err_q);
        idx_d   = is_last ? idx_q : idx_q + 1'b1;
        state_d = is_last ? DONE : RD_REQ;
      end
      DONE: begin
        pass_d = pass_now;
        if (loop_mode && !timeout_q) begin
          seed_d  = seed_q + SEED_STEP;
          idx_d   = '0;
          state_d = WR_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A handshake that stalls in place for TIMEOUT_CYCLES aborts the pass.
    if ((state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) && (state_d == state_q) &&
        (wait_q == WAIT_LAST)) begin
      timeout_d = 1'b1;
      err_d     = sat_inc(err_q);
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      state_d   = DONE;
    end

    // Request channels are loaded on state entry and then held until handshake.
    if (state_d != state_q) begin
      wait_d = '0;
      if (state_d == WR_REQ) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        addr_d    = reg_addr(idx_d);
        wdata_d   = seed_d + DATA_WIDTH'(idx_d);
      end
      if (state_d == RD_REQ) begin
        arvalid_d = 1'b1;
        addr_d    = reg_addr(idx_d);
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      seed_q    <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      wait_q    <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seed_q    <= seed_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pass      = done ? pass_now : pass_q;
  assign timeout   = timeout_q;
  assign err_count = err_q;

  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.WDATA   = wdata_q;
  assign m_axi.WSTRB   = {(DATA_WIDTH/8){wvalid_q}};
  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.BREADY  = (state_q == WR_RESP);
  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.RREADY  = (state_q == RD_RESP);

endmodule
